lpc_encode_sequencer: RTL

Parametrised multi-frame successor to the single-shot LPC encode controller. It sequences autocorrelation, Levinson-Durbin and inverse filter over a programmable number of frames, or runs continuously. Each stage gets a one-cycle start pulse, and the sequencer waits for a frame-ready handshake between frames. A compile-time watchdog is optional; when enabled, a stalled stage drives the sequencer into a sticky error state. The block sits above the three datapath stages and drives their start pulses and the shared memory read-port selects.

---
 rtl/lpc_encode_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lpc_encode_sequencer.sv
// Multi-frame LPC encode sequencer: autocorrelation -> Levinson -> inverse filter per frame.
// Optional stall watchdog enabled by defining LPC_SEQ_WATCHDOG_EN.
//
// state        | meaning
// IDLE         | waiting for start
// AC_START     | autocorrelation start pulse
// AC_RUN       | waiting for ready_autocorrelation
// LEV_START    | Levinson-Durbin start pulse
// LEV_RUN      | waiting for ready_levinson
// IF_START     | inverse filter start pulse
// IF_RUN       | waiting for ready_ifilter
// FRAME_END    | frame completed, frame_done pulse
// WAIT_FRAME   | waiting for next frame's samples
// ERROR        | stage stalled (watchdog only), sticky until abort/reset
module lpc_encode_sequencer #(
  parameter int FRAME_W   = 8,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic               frame_ready,
  input  logic               ready_autocorrelation,
  input  logic               ready_levinson,
  input  logic               ready_ifilter,
  output logic               reset_autocorrelation,
  output logic               reset_levinson,
  output logic               reset_ifilter,
  output logic               a_rsel_sel,
  output logic               x_raddr_sel,
  output logic               busy,
  output logic               frame_done,
  output logic               done,
  output logic [FRAME_W-1:0] frame_index,
  output logic               error,
  output logic [1:0]         error_stage
);

  typedef enum logic [3:0] {
    S_IDLE, S_AC_START, S_AC_RUN, S_LEV_START, S_LEV_RUN,
    S_IF_START, S_IF_RUN, S_FRAME_END, S_WAIT_FRAME, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_index_q, frame_index_d;
  logic [FRAME_W-1:0] count_q, count_d;
  logic [FRAME_W-1:0] frame_inc;
  logic               frame_done_d, done_d;

`ifdef LPC_SEQ_WATCHDOG_EN
  // Down-counter loaded on RUN entry; terminal count of 1 means this is the TIMEOUT-th stalled cycle.
  localparam logic [TIMEOUT_W-1:0] WD_LOAD = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [1:0]           err_stage_q, err_stage_d;
`endif

  assign frame_inc   = frame_index_q + 1'b1;
  assign frame_index = frame_index_q;

  always_comb begin
    state_d       = state_q;
    frame_index_d = frame_index_q;
    count_d       = count_q;
    frame_done_d  = 1'b0;
    done_d        = 1'b0;
`ifdef LPC_SEQ_WATCHDOG_EN
    wd_d        = wd_q;
    err_stage_d = err_stage_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_AC_START;
          count_d       = num_frames;
          frame_index_d = '0;
        end
      end
      S_AC_START: begin
        state_d = S_AC_RUN;
`ifdef LPC_SEQ_WATCHDOG_EN
        wd_d = WD_LOAD;
`endif
      end
      S_AC_RUN: begin
        if (ready_autocorrelation) state_d = S_LEV_START;
`ifdef LPC_SEQ_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          state_d     = S_ERROR;
          err_stage_d = 2'd1;
        end else wd_d = wd_q - 1'b1;
`endif
      end
      S_LEV_START: begin
        state_d = S_LEV_RUN;
`ifdef LPC_SEQ_WATCHDOG_EN
        wd_d = WD_LOAD;
`endif
      end
      S_LEV_RUN: begin
        if (ready_levinson) state_d = S_IF_START;
`ifdef LPC_SEQ_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          state_d     = S_ERROR;
          err_stage_d = 2'd2;
        end else wd_d = wd_q - 1'b1;
`endif
      end
      S_IF_START: begin
        state_d = S_IF_RUN;
`ifdef LPC_SEQ_WATCHDOG_EN
        wd_d = WD_LOAD;
`endif
      end
      S_IF_RUN: begin
        if (ready_ifilter) begin
          state_d       = S_FRAME_END;
          frame_index_d = frame_inc;
          frame_done_d  = 1'b1;
          done_d        = (count_q != '0) && (frame_inc == count_q);
        end
`ifdef LPC_SEQ_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          state_d     = S_ERROR;
          err_stage_d = 2'd3;
        end else wd_d = wd_q - 1'b1;
`endif
      end
      S_FRAME_END: begin
        // done is registered on FRAME_END entry, so it already marks the final frame here
        if (done)             state_d = S_IDLE;
        else if (frame_ready) state_d = S_AC_START;
        else                  state_d = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (frame_ready) state_d = S_AC_START;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d       = S_IDLE;
      frame_index_d = frame_index_q;
      count_d       = count_q;
      frame_done_d  = 1'b0;
      done_d        = 1'b0;
`ifdef LPC_SEQ_WATCHDOG_EN
      err_stage_d = 2'd0;
`endif
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= S_IDLE;
      frame_index_q         <= '0;
      count_q               <= '0;
      reset_autocorrelation <= 1'b0;
      reset_levinson        <= 1'b0;
      reset_ifilter         <= 1'b0;
      a_rsel_sel            <= 1'b0;
      x_raddr_sel           <= 1'b0;
      busy                  <= 1'b0;
      frame_done            <= 1'b0;
      done                  <= 1'b0;
`ifdef LPC_SEQ_WATCHDOG_EN
      wd_q        <= '0;
      err_stage_q <= 2'd0;
      error       <= 1'b0;
`endif
    end else begin
      state_q               <= state_d;
      frame_index_q         <= frame_index_d;
      count_q               <= count_d;
      reset_autocorrelation <= (state_d == S_AC_START);
      reset_levinson        <= (state_d == S_LEV_START);
      reset_ifilter         <= (state_d == S_IF_START);
      a_rsel_sel            <= (state_d == S_IF_START) || (state_d == S_IF_RUN);
      x_raddr_sel           <= (state_d == S_IF_START) || (state_d == S_IF_RUN);
      busy                  <= (state_d != S_IDLE) && (state_d != S_ERROR);
      frame_done            <= frame_done_d;
      done                  <= done_d;
`ifdef LPC_SEQ_WATCHDOG_EN
      wd_q        <= wd_d;
      err_stage_q <= err_stage_d;
      error       <= (state_d == S_ERROR);
`endif
    end
  end

`ifdef LPC_SEQ_WATCHDOG_EN
  assign error_stage = err_stage_q;
`else
  assign error       = 1'b0;
  assign error_stage = 2'd0;
`endif

endmodule
